// File: rtl/branch_pkg.sv
// Shared definitions for the branch PC sequencer: funct3 branch codes, FSM states, PC step.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [63:0] PC_STEP = 64'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } pcs_state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition decode for the conditional branch funct3 codes.
module branch_cond
   import branch_pkg::*;
(
   input  logic        branch,
   input  logic        zero,
   input  logic [2:0]  funct3,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        cond
);

   logic signed [63:0] a_s;
   logic signed [63:0] b_s;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      cond = 1'b0;
      if (branch) begin
         unique case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = !zero;
            F3_BLT:  cond = (a_s < b_s);
            F3_BGE:  cond = (a_s >= b_s);
            F3_BLTU: cond = (a < b);
            F3_BGEU: cond = (a >= b);
            default: cond = 1'b0;  // 010/011 are not branches
         endcase
      end
   end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Sequenced PC controller: fetch handshake, wait for execute, resolve branch, update PC.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_pc_sequencer
   import branch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          CNT_W    = 32
)
(
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [63:0]       imem_addr,
   input  logic              imem_ack,
   input  logic              ex_valid,
   input  logic              branch,
   input  logic              zero,
   input  logic [2:0]        funct3,
   input  logic [63:0]       a,
   input  logic [63:0]       b,
   input  logic [63:0]       imm,
   output logic [63:0]       pc,
   output logic              taken,
   output logic              misalign
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  taken_cnt
`endif
);

   pcs_state_t  state;
   logic        cond;
   logic        resolve;
   logic        take_ok;
   logic [63:0] target;
   logic [63:0] fall;

   branch_cond u_cond (
      .branch (branch),
      .zero   (zero),
      .funct3 (funct3),
      .a      (a),
      .b      (b),
      .cond   (cond)
   );

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;

   assign resolve = (state == EXEC) && ex_valid;
   assign target  = pc + imm;
   assign fall    = pc + PC_STEP;
   assign take_ok = cond && (target[1:0] == 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         taken    <= 1'b0;
         misalign <= 1'b0;
      end else begin
         taken    <= 1'b0;
         misalign <= 1'b0;
         case (state)
            IDLE:  state <= FETCH;
            FETCH: if (imem_ack) state <= EXEC;
            EXEC: begin
               if (ex_valid) begin
                  state    <= FETCH;
                  pc       <= take_ok ? target : fall;
                  taken    <= take_ok;
                  misalign <= cond && (target[1:0] != 2'b00);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         if (resolve && branch && (branch_cnt != '1))
            branch_cnt <= branch_cnt + CNT_W'(1);
         if (resolve && take_ok && (taken_cnt != '1))
            taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
